// File: rtl/add_pipe_pkg.sv
// Shared widths, carry helper and reset constants for the two-stage add/sub pipeline.
package add_pipe_pkg;

  localparam int HALF = 16;
  localparam int W    = 2 * HALF;

  localparam logic [HALF-1:0] HALF_RST = '0;
  localparam logic [W-1:0]    WORD_RST = '0;

  // Carry out of a lookahead slice from its group generate/propagate.
  function automatic logic carry(input logic g, input logic p, input logic cin);
    return g | (p & cin);
  endfunction

endpackage

// File: rtl/cla_16.sv
// 16-bit carry-lookahead slice: four 4-bit groups with a second lookahead level.
// Exposes group generate/propagate only; callers form the carry-out themselves.
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        g_out,
  output logic        p_out
);

  always_comb begin : cla
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    g = a & b;
    p = a ^ b;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | ((&p[4*k+3 -: 2]) & g[4*k+1])
            | ((&p[4*k+3 -: 3]) & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = c_in;
    for (int k = 0; k < 3; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    sum   = p ^ c;
    g_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]);
    p_out = &gp;
  end

endmodule

// File: rtl/add_pipe_32.sv
// Two-stage pipelined 32-bit adder/subtractor with valid/ready on both sides.
// Define ADD_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module add_pipe_32
  import add_pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         out_valid,
`ifdef ADD_PIPE_OVF_EN
  output logic         ovf,
`endif
  input  logic         out_ready
);

  logic [W-1:0]    bx;
  logic            cx;
  logic [HALF-1:0] lo_sum;
  logic [HALF-1:0] hi_sum;
  logic            g0, p0, g1, p1;

  logic            s1_valid_q, s1_valid_d;
  logic [HALF-1:0] lo_sum_q, lo_sum_d;
  logic [HALF-1:0] a_hi_q, a_hi_d;
  logic [HALF-1:0] bx_hi_q, bx_hi_d;
  logic            c16_q, c16_d;

  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            out_valid_q, out_valid_d;

  logic            s2_free, s1_adv, accept;

  assign bx = sub ? ~b : b;
  assign cx = sub | c_in;

  cla_16 u_lo (
    .a     (a[HALF-1:0]),
    .b     (bx[HALF-1:0]),
    .c_in  (cx),
    .sum   (lo_sum),
    .g_out (g0),
    .p_out (p0)
  );

  cla_16 u_hi (
    .a     (a_hi_q),
    .b     (bx_hi_q),
    .c_in  (c16_q),
    .sum   (hi_sum),
    .g_out (g1),
    .p_out (p1)
  );

  // Stage 1 may reload in the same cycle it hands its contents to stage 2.
  assign s2_free  = !out_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_free;
  assign in_ready = !s1_valid_q | s2_free;
  assign accept   = in_valid & in_ready;

`ifdef ADD_PIPE_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latch).
    s1_valid_d  = s1_valid_q;
    lo_sum_d    = lo_sum_q;
    a_hi_d      = a_hi_q;
    bx_hi_d     = bx_hi_q;
    c16_d       = c16_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
`ifdef ADD_PIPE_OVF_EN
    ovf_d       = ovf_q;
`endif

    if (accept) begin
      lo_sum_d = lo_sum;
      c16_d    = carry(g0, p0, cx);
      a_hi_d   = a[W-1:HALF];
      bx_hi_d  = bx[W-1:HALF];
    end
    s1_valid_d = accept | (s1_valid_q & !s1_adv);

    if (s1_adv) begin
      sum_d       = {hi_sum, lo_sum_q};
      c_out_d     = carry(g1, p1, c16_q);
      out_valid_d = 1'b1;
`ifdef ADD_PIPE_OVF_EN
      // a[31] and bx[31] ride forward as the top bits of the high operands.
      ovf_d = (a_hi_q[HALF-1] == bx_hi_q[HALF-1]) & (hi_sum[HALF-1] != a_hi_q[HALF-1]);
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_sum_q    <= HALF_RST;
      a_hi_q      <= HALF_RST;
      bx_hi_q     <= HALF_RST;
      c16_q       <= 1'b0;
      sum_q       <= WORD_RST;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADD_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_sum_q    <= lo_sum_d;
      a_hi_q      <= a_hi_d;
      bx_hi_q     <= bx_hi_d;
      c16_q       <= c16_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
`ifdef ADD_PIPE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_pipe_32.sv
// Self-checking bench for add_pipe_32: directed vectors, back-pressure, reset
// mid-flight and randomized traffic against an arithmetic reference model.
module tb_add_pipe_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        c_in, sub, in_valid, out_ready;
  logic        in_ready, c_out, out_valid;
  logic [31:0] sum;
`ifdef ADD_PIPE_OVF_EN
  logic        ovf;
`endif

  add_pipe_32 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid),
`ifdef ADD_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc, n_acc, n_pop, first_pop, last_pop;
  logic accepted;
  res_t exp_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Unsigned modulo-2^32 result; subtraction carry means a >= b; overflow from exact signed sum.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    res_t        r;
    logic [32:0] t;
    longint      sx, sy, ss;
    longint      max_s = 64'sd2147483647;
    longint      min_s = -64'sd2147483648;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      ss     = sx - sy;
    end else begin
      t      = {1'b0, x} + {1'b0, y} + {32'b0, ci};
      r.sum  = t[31:0];
      r.cout = t[32];
      ss     = sx + sy + (ci ? 64'sd1 : 64'sd0);
    end
    r.ovf = (ss > max_s) || (ss < min_s);
    return r;
  endfunction

  // Inputs are already driven at the falling edge; sample handshakes, then advance one cycle.
  task automatic tick();
    res_t e;
    #1;
    accepted = in_valid && in_ready;
    if (accepted) begin
      exp_q.push_back(model(a, b, c_in, sub));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_sum", sum, e.sum);
        check("sb_cout", c_out, e.cout);
`ifdef ADD_PIPE_OVF_EN
        check("sb_ovf", ovf, e.ovf);
`endif
      end
      if (n_pop == 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input vec_t v, input int idx);
    a = v.a; b = v.b; c_in = v.c_in; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check($sformatf("v%0d_in_ready", idx), in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check($sformatf("v%0d_valid_n1", idx), out_valid, 1'b0);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_valid_n2", idx), out_valid, 1'b1);
    check($sformatf("v%0d_sum", idx), sum, v.sum);
    check($sformatf("v%0d_cout", idx), c_out, v.cout);
`ifdef ADD_PIPE_OVF_EN
    check($sformatf("v%0d_ovf", idx), ovf, v.ovf);
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    res_t        r0;
    int          k;

    vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[7] = '{32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0};
    vecs[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_c_out", c_out, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef ADD_PIPE_OVF_EN
    check("rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_one(vecs[i], i);

    // Back-pressure: four back-to-back ops, consumer stalls in cycles 2..5.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = $urandom;
      bp_b[i] = $urandom;
    end
    r0 = model(bp_a[0], bp_b[0], 1'b0, 1'b0);
    exp_q.delete();
    n_acc = 0; n_pop = 0; cyc = 0; first_pop = -1; last_pop = -1; k = 0;
    c_in = 1'b0; sub = 1'b0;
    for (int c = 0; c < 20 && n_pop < 4; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (k < 4);
      a = bp_a[k < 4 ? k : 3];
      b = bp_b[k < 4 ? k : 3];
      #1;
      if (c == 2) begin
        check("bp_ready_drop", in_ready, 1'b0);
        check("bp_accepts_before_stall", n_acc, 2);
      end
      if (c >= 2 && c <= 5) begin
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_sum", sum, r0.sum);
        check("bp_hold_cout", c_out, r0.cout);
      end
      tick();
      if (accepted) k++;
    end
    in_valid = 1'b0;
    check("bp_results", n_pop, 4);
    check("bp_first_pop", first_pop, 6);
    check("bp_last_pop", last_pop, 9);

    // Randomized traffic with random stalls.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      case ($urandom_range(7))
        0:       a = 32'hFFFFFFFF;
        1:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(7))
        0:       b = 32'h7FFFFFFF;
        1:       b = 32'h00000000;
        default: b = $urandom;
      endcase
      c_in = $urandom_range(1);
      sub  = $urandom_range(1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && (exp_q.size() != 0 || out_valid); c++) tick();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 1'b0);

    // Reset mid-flight: two ops in the pipe, then reset with a new op offered.
    n_pop = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h11111111; b = 32'h22222222;
    tick();
    a = 32'h33333333; b = 32'h44444444;
    tick();
    rst = 1'b1;
    a = 32'h55555555; b = 32'h66666666;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 32'h0);
    check("mid_rst_c_out", c_out, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    n_pop = 0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) tick();
    check("mid_rst_no_stale", n_pop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
